// File: rtl/elevator_controller_n.sv
// N-floor SCAN elevator controller: latches calls, travels floor by floor, dwells with door open.
// Optional emergency stop input is compiled in when ELEV_ESTOP_EN is defined.
module elevator_controller_n #(
    parameter int NUM_FLOORS    = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3,
    localparam int FLOOR_W      = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
`ifdef ELEV_ESTOP_EN
    input  logic                  estop,
`endif
    output logic [FLOOR_W-1:0]    floor,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [1:0]            state_dbg
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    state_t                  state_q;
    logic [FLOOR_W-1:0]      floor_q;
    logic                    moving_q;
    logic                    dir_up_q;
    logic                    door_open_q;
    logic [NUM_FLOORS-1:0]   pending_q;
    logic [NUM_FLOORS-1:0]   pending_d;
    logic [TW-1:0]           travel_q;
    logic [DW-1:0]           door_q;

    logic                    halt;
    logic                    any_above;
    logic                    any_below;
    logic [FLOOR_W-1:0]      step_floor;
    logic                    arrive;
    logic                    stop_here;
    logic                    same_floor;

`ifdef ELEV_ESTOP_EN
    assign halt = estop;
`else
    assign halt = 1'b0;
`endif

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(floor_q)) any_above = any_above | pending_q[i];
            if (i < int'(floor_q)) any_below = any_below | pending_q[i];
        end
        step_floor = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        arrive     = (state_q == MOVE) && !halt && (travel_q == TW'(TRAVEL_CYCLES - 1));
        stop_here  = pending_q[step_floor] | req[step_floor];
        same_floor = req[floor_q] | pending_q[floor_q];

        // A call at the floor the cab is parked at is answered by the door, never latched.
        pending_d = pending_q | req;
        if (state_q != MOVE) pending_d[floor_q] = pending_q[floor_q];
        if (state_q == IDLE && same_floor) pending_d[floor_q] = 1'b0;
        if (arrive && stop_here) pending_d[step_floor] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            moving_q    <= 1'b0;
            dir_up_q    <= 1'b1;
            door_open_q <= 1'b0;
            pending_q   <= '0;
            travel_q    <= '0;
            door_q      <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (same_floor) begin
                        state_q     <= DOOR;
                        door_open_q <= 1'b1;
                        door_q      <= '0;
                    end else if (!halt && pending_q != '0) begin
                        // Keep heading the same way while calls remain ahead, otherwise reverse.
                        dir_up_q <= dir_up_q ? any_above : !any_below;
                        state_q  <= MOVE;
                        moving_q <= 1'b1;
                        travel_q <= '0;
                    end
                end
                MOVE: begin
                    if (halt) begin
                        moving_q <= 1'b0;
                    end else if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
                        floor_q <= step_floor;
                        if (stop_here) begin
                            state_q     <= DOOR;
                            moving_q    <= 1'b0;
                            door_open_q <= 1'b1;
                            door_q      <= '0;
                        end else begin
                            moving_q <= 1'b1;
                            travel_q <= '0;
                        end
                    end else begin
                        moving_q <= 1'b1;
                        travel_q <= travel_q + TW'(1);
                    end
                end
                DOOR: begin
                    if (!halt) begin
                        if (req[floor_q]) begin
                            door_q <= '0;
                        end else if (door_q == DW'(DOOR_CYCLES - 1)) begin
                            state_q     <= IDLE;
                            door_open_q <= 1'b0;
                        end else begin
                            door_q <= door_q + DW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign floor     = floor_q;
    assign moving    = moving_q;
    assign dir_up    = dir_up_q;
    assign door_open = door_open_q;
    assign pending   = pending_q;
    assign state_dbg = state_q;

    assert property (@(posedge clk) disable iff (rst) !(moving_q && door_open_q));
    assert property (@(posedge clk) disable iff (rst)
        arrive |-> (dir_up_q ? (floor_q != FLOOR_W'(NUM_FLOORS - 1)) : (floor_q != '0)));

endmodule

// File: tb/tb_elevator_controller_n.sv
// Bench for elevator_controller_n: directed call scenarios, expected output-change events
// (cycle stamp + outputs) queued by the driver and checked by an independent monitor.
module tb_elevator_controller_n;

    localparam int W = 25;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       estop;
    logic [1:0] floor;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic [3:0] pending;
    logic [1:0] state_dbg;

    elevator_controller_n #(
        .NUM_FLOORS(4),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
`ifdef ELEV_ESTOP_EN
        .estop(estop),
`endif
        .floor(floor),
        .moving(moving),
        .dir_up(dir_up),
        .door_open(door_open),
        .pending(pending),
        .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    logic [8:0] prev_snap;

    function automatic logic [W-1:0] ev(input int stamp, input int fl, input bit mv,
                                        input bit up, input bit dr, input logic [3:0] pend);
        return {16'(stamp), 2'(fl), mv, up, dr, pend};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [8:0]   cur;
        logic [W-1:0] got;
        logic [W-1:0] e;
        cur = {floor, moving, dir_up, door_open, pending};
        if (mon_en) begin
            checks++;
            if (moving && door_open) begin
                failures++;
                $display("FAIL invariant: moving and door_open both 1 at cyc=%0d", cyc);
            end
            if (cur != prev_snap) begin
                got = {16'(cyc), cur};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got cyc=%0d fl/mv/up/dr/pend=%b, expected none",
                             cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        failures++;
                        $display("FAIL event: got cyc=%0d fl/mv/up/dr/pend=%b expected cyc=%0d fl/mv/up/dr/pend=%b",
                                 got[24:9], got[8:0], e[24:9], e[8:0]);
                    end
                end
            end
        end
        prev_snap = cur;
    end

    // driver tasks
    task automatic pulse(input logic [3:0] mask);
        req = mask;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        req = '0;
        estop = 1'b0;
        wait_neg(3);
        chk("reset_floor", int'(floor), 0);
        chk("reset_moving", int'(moving), 0);
        chk("reset_dir_up", int'(dir_up), 1);
        chk("reset_door_open", int'(door_open), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_state", int'(state_dbg), 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        mon_en = 1'b1;

        // 1: single call from floor 0 to floor 2
        @(negedge clk);
        k = cyc + 1;
        exp_q.push_back(ev(k,      0, 0, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 1,  0, 1, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 5,  1, 1, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 9,  2, 0, 1, 1, 4'b0000));
        exp_q.push_back(ev(k + 12, 2, 0, 1, 0, 4'b0000));
        pulse(4'b0100);
        wait_neg(15);

        // 2: SCAN pickup of floor 1 on the way to floor 3
        do_reset();
        @(negedge clk);
        k = cyc + 1;
        exp_q.push_back(ev(k,      0, 0, 1, 0, 4'b1000));
        exp_q.push_back(ev(k + 1,  0, 1, 1, 0, 4'b1000));
        exp_q.push_back(ev(k + 3,  0, 1, 1, 0, 4'b1010));
        exp_q.push_back(ev(k + 5,  1, 0, 1, 1, 4'b1000));
        exp_q.push_back(ev(k + 8,  1, 0, 1, 0, 4'b1000));
        exp_q.push_back(ev(k + 9,  1, 1, 1, 0, 4'b1000));
        exp_q.push_back(ev(k + 13, 2, 1, 1, 0, 4'b1000));
        exp_q.push_back(ev(k + 17, 3, 0, 1, 1, 4'b0000));
        exp_q.push_back(ev(k + 20, 3, 0, 1, 0, 4'b0000));
        pulse(4'b1000);
        wait_neg(2);
        pulse(4'b0010);
        wait_neg(20);

        // 3: reversal from floor 3 with calls at 0 and 2
        @(negedge clk);
        k = cyc + 1;
        exp_q.push_back(ev(k,      3, 0, 1, 0, 4'b0101));
        exp_q.push_back(ev(k + 1,  3, 1, 0, 0, 4'b0101));
        exp_q.push_back(ev(k + 5,  2, 0, 0, 1, 4'b0001));
        exp_q.push_back(ev(k + 8,  2, 0, 0, 0, 4'b0001));
        exp_q.push_back(ev(k + 9,  2, 1, 0, 0, 4'b0001));
        exp_q.push_back(ev(k + 13, 1, 1, 0, 0, 4'b0001));
        exp_q.push_back(ev(k + 17, 0, 0, 0, 1, 4'b0000));
        exp_q.push_back(ev(k + 20, 0, 0, 0, 0, 4'b0000));
        pulse(4'b0101);
        wait_neg(22);

        // reversal at the bottom: dir_up=0 at floor 0, call above turns the cab up
        @(negedge clk);
        k = cyc + 1;
        exp_q.push_back(ev(k,     0, 0, 0, 0, 4'b0010));
        exp_q.push_back(ev(k + 1, 0, 1, 1, 0, 4'b0010));
        exp_q.push_back(ev(k + 5, 1, 0, 1, 1, 4'b0000));
        exp_q.push_back(ev(k + 8, 1, 0, 1, 0, 4'b0000));
        pulse(4'b0010);
        wait_neg(10);

        // 4: same-floor call opens the door, repeat call restarts the dwell
        @(negedge clk);
        k = cyc + 1;
        exp_q.push_back(ev(k,     1, 0, 1, 1, 4'b0000));
        exp_q.push_back(ev(k + 5, 1, 0, 1, 0, 4'b0000));
        pulse(4'b0010);
        wait_neg(1);
        pulse(4'b0010);
        wait_neg(8);

        // 5: reset while travelling from 0 toward 2
        do_reset();
        @(negedge clk);
        k = cyc + 1;
        exp_q.push_back(ev(k,     0, 0, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 1, 0, 1, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 5, 1, 1, 1, 0, 4'b0100));
        pulse(4'b0100);
        wait_neg(6);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("midmove_rst_floor", int'(floor), 0);
        chk("midmove_rst_moving", int'(moving), 0);
        chk("midmove_rst_pending", int'(pending), 0);
        chk("midmove_rst_door_open", int'(door_open), 0);
        chk("midmove_rst_dir_up", int'(dir_up), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        mon_en = 1'b1;

`ifdef ELEV_ESTOP_EN
        // 6: five-cycle emergency stop mid-travel delays arrival by five cycles
        @(negedge clk);
        k = cyc + 1;
        exp_q.push_back(ev(k,      0, 0, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 1,  0, 1, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 3,  0, 0, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 8,  0, 1, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 10, 1, 1, 1, 0, 4'b0100));
        exp_q.push_back(ev(k + 14, 2, 0, 1, 1, 4'b0000));
        exp_q.push_back(ev(k + 17, 2, 0, 1, 0, 4'b0000));
        pulse(4'b0100);
        wait_neg(2);
        estop = 1'b1;
        wait_neg(5);
        estop = 1'b0;
        wait_neg(12);
`endif

        wait_neg(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
